lift_scan_ctrl: RTL and testbench
=================================

# lift_scan_ctrl

Parametrised elevator controller for an N-floor car, the next generation of the single-request lift FSM. It latches any number of floor calls into a pending bitmap and serves them in SCAN (elevator-algorithm) order. Floor travel and door dwell are timed by parametrised counters, and a door-hold input extends the dwell. Outputs drive the 7-segment floor display wrapper and the status LEDs on the board top level.

## Interface

Parameters:
- FLOORS, 8, number of floors (2..16); floors are numbered 0..FLOORS-1.
- FLOOR_W, $clog2(FLOORS), width of the floor index. Derived; do not override.
- MOVE_CYCLES, 4, clock cycles to travel one floor (>=1).
- DOOR_CYCLES, 4, clock cycles the doors stay open (>=1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- call_req  in  FLOORS  call pulses from hall and cabin buttons, OR-combined. Bit i requests floor i. Level or pulse, sampled every cycle.
- door_hold  in  1  while high in DOORS, the dwell timer freezes.
- floor_o  out  FLOOR_W  current car floor.
- dir_up  out  1  travel direction preference: 1 = up, 0 = down.
- moving  out  1  high while in MOVE.
- doors_open  out  1  high while in DOORS.
- arrive  out  1  one-cycle pulse on each floor_o change.
- pending  out  FLOORS  registered outstanding-call bitmap.

## Operation

- States: IDLE, MOVE, DOORS (2-bit encoding).
- Reset values: state=IDLE, floor_o=0, dir_up=1, moving=0, doors_open=0, arrive=0, pending=0, both counters 0.
- Pending update, every cycle: pending <= (pending | call_req) & ~clr.
  - clr is the one-hot mask of floor_o on any cycle where the FSM enters DOORS or is in DOORS.
  - A call for the current floor is therefore never latched while the doors are open or opening.
- ahead = any pending bit strictly beyond floor_o in dir_up's direction. behind = any pending bit strictly on the other side.
- Decision rule D, applied in IDLE, at each MOVE arrival, and at DOORS expiry:
  - If pending[floor_o] is set, go to DOORS.
  - Else if ahead, go to MOVE and keep dir_up.
  - Else if behind, invert dir_up and go to MOVE.
  - Else go to IDLE.
  - At a MOVE arrival, D uses the updated floor_o.
- IDLE: evaluate D every cycle. Stay in IDLE while pending == 0.
- MOVE:
  - The travel counter increments each cycle.
  - On reaching MOVE_CYCLES-1: counter clears, floor_o steps ±1 per dir_up, arrive=1 for that one cycle, and D is evaluated.
  - Calls that become pending ahead of the car before it reaches that floor are served en route.
- DOORS:
  - The dwell counter increments each cycle, unless door_hold=1, in which case it holds.
  - A call_req bit for floor_o during DOORS restarts the dwell counter at 0.
  - On reaching DOOR_CYCLES-1 with no hold and no restart: doors_open drops and D is evaluated. A re-entry into DOORS is impossible at that point, because the current-floor bit is cleared.
- Bounds:
  - floor_o never goes below 0 or above FLOORS-1. SCAN guarantees this; implement an assertion, and saturate in RTL as a guard.
  - call_req bits have exactly FLOORS width, so no out-of-range request exists.
- Reset mid-operation (any state): all registers return to their reset values on the next edge, and pending calls are discarded.

## Timing

- A call sampled at edge k sets pending after edge k. The FSM acts on it at edge k+1; moving or doors_open is high after edge k+1.
- In MOVE, floor_o changes on the MOVE_CYCLES-th edge after MOVE entry, then every MOVE_CYCLES edges. The arrive pulse coincides with the new floor_o value.
- doors_open is high for exactly DOOR_CYCLES cycles absent hold or restart; hold adds one cycle per held cycle.
- Stopping at a floor: the MOVE→DOORS transition happens on the same edge as the floor_o update, so there is no dead cycle.
- Minimum IDLE→arrival→doors latency for one floor: 1 + MOVE_CYCLES cycles.
- All outputs are registered; no combinational path from call_req or door_hold to any output.

## Test plan

Run with FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=3.

- Reset, then call_req=8'h08 for 1 cycle -> floor_o steps 0→1→2→3, 4 cycles apart, with 3 arrive pulses. doors_open is high for 3 cycles at floor 3, pending returns to 0, FSM ends in IDLE with dir_up=1.
- Idle at floor 3 with dir_up=1; call_req=8'h22 (floors 1 and 5) in the same cycle -> car serves 5 first, dir_up flips to 0, then serves 1. Door openings occur at 5 then 1.
- Idle at floor 2; call_req bit 2 -> doors_open=1 the next cycle, moving never asserts, pending[2] never reads 1.
- In DOORS at floor 3: door_hold high for 5 cycles -> doors_open lasts 8 cycles. A separate run pulses call_req bit 3 on the 2nd door cycle -> dwell restarts and doors stay open 5 cycles in total.
- Moving up from floor 1 toward 6; call bit 4 asserted while floor_o=2 -> car stops at 4 (doors 3 cycles), then continues to 6.
- Assert rst during MOVE at floor 4 with pending=8'h40 -> after the next edge, floor_o=0, pending=0, moving=0, and state is IDLE.

Source files
------------

// File: rtl/lift_scan_ctrl.sv
// ---------------------------------------------------------------------------
// lift_scan_ctrl
//
// Purpose:
//   Elevator controller for an N-floor car. Floor calls are latched into a
//   pending bitmap and served in SCAN (elevator-algorithm) order: the car
//   keeps its travel direction while calls remain ahead of it, and reverses
//   only when nothing is left in that direction. Floor travel and door dwell
//   are timed by counters, and a door-hold input freezes the dwell.
//
// Parameters:
//   FLOORS      number of floors (2..16), numbered 0..FLOORS-1
//   FLOOR_W     width of the floor index (derived, leave at default)
//   MOVE_CYCLES clock cycles to travel one floor (>=1)
//   DOOR_CYCLES clock cycles the doors stay open (>=1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   call_req   in   OR-combined hall/cabin call bits, bit i = floor i
//   door_hold  in   freezes the dwell timer while the doors are open
//   floor_o    out  current car floor
//   dir_up     out  travel direction preference (1 = up, 0 = down)
//   moving     out  high while the car travels
//   doors_open out  high while the doors are open
//   arrive     out  one-cycle pulse on every floor_o change
//   pending    out  registered outstanding-call bitmap
// ---------------------------------------------------------------------------
module lift_scan_ctrl #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = $clog2(FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  call_req,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] floor_o,
  output logic               dir_up,
  output logic               moving,
  output logic               doors_open,
  output logic               arrive,
  output logic [FLOORS-1:0]  pending
);

  // A counter for a single-cycle period still needs one bit to exist.
  localparam int MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [MOVE_W-1:0]  MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
  localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DOORS = 2'd2
  } state_t;

  typedef struct packed {
    state_t st;
    logic   up;
  } decision_t;

  state_t             state;
  state_t             state_next;
  logic [MOVE_W-1:0]  move_cnt;
  logic [MOVE_W-1:0]  move_cnt_next;
  logic [DOOR_W-1:0]  door_cnt;
  logic [DOOR_W-1:0]  door_cnt_next;
  logic [FLOOR_W-1:0] floor_next;
  logic [FLOOR_W-1:0] stepped_floor;
  logic               dir_next;
  logic [FLOORS-1:0]  clr_mask;
  logic [FLOORS-1:0]  pending_next;
  logic               moving_next;
  logic               doors_open_next;
  logic               arrive_next;
  decision_t          dec;

  // SCAN decision for a car standing at floor f with direction up. A call
  // for the floor itself, whether already pending or arriving this very
  // cycle, opens the doors at once so that it never lands in the bitmap.
  // Otherwise the car keeps going while anything is strictly ahead, turns
  // round when the only work is behind it, and idles when nothing is left.
  function automatic decision_t decide(
    input logic [FLOOR_W-1:0] f,
    input logic               up,
    input logic [FLOORS-1:0]  pend,
    input logic [FLOORS-1:0]  req
  );
    logic      above;
    logic      below;
    logic      ahead;
    logic      behind;
    decision_t d;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pend[i]) begin
        if (i > int'(f)) above = 1'b1;
        if (i < int'(f)) below = 1'b1;
      end
    end
    ahead  = up ? above : below;
    behind = up ? below : above;
    d.st   = IDLE;
    d.up   = up;
    if (pend[f] || req[f]) begin
      d.st = DOORS;
    end else if (ahead) begin
      d.st = MOVE;
    end else if (behind) begin
      d.st = MOVE;
      d.up = ~up;
    end
    return d;
  endfunction

  // State register: every piece of state, including the outputs, is held
  // here so nothing combinational leaks from call_req or door_hold to a pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      move_cnt   <= '0;
      door_cnt   <= '0;
      floor_o    <= '0;
      dir_up     <= 1'b1;
      pending    <= '0;
      moving     <= 1'b0;
      doors_open <= 1'b0;
      arrive     <= 1'b0;
    end else begin
      state      <= state_next;
      move_cnt   <= move_cnt_next;
      door_cnt   <= door_cnt_next;
      floor_o    <= floor_next;
      dir_up     <= dir_next;
      pending    <= pending_next;
      moving     <= moving_next;
      doors_open <= doors_open_next;
      arrive     <= arrive_next;
    end
  end

  // Next-state logic. The SCAN decision runs in IDLE every cycle, at the
  // end of each floor of travel (against the floor just reached, so a stop
  // there costs no extra cycle), and when the dwell expires. A call for the
  // current floor while the doors are open restarts the dwell and takes
  // priority over door_hold; the floor step saturates at both ends purely
  // as a guard, since SCAN never heads past the last call.
  always_comb begin
    state_next    = state;
    floor_next    = floor_o;
    dir_next      = dir_up;
    move_cnt_next = move_cnt;
    door_cnt_next = door_cnt;
    stepped_floor = floor_o;
    dec           = '0;
    case (state)
      IDLE: begin
        dec           = decide(floor_o, dir_up, pending, call_req);
        state_next    = dec.st;
        dir_next      = dec.up;
        move_cnt_next = '0;
        door_cnt_next = '0;
      end
      MOVE: begin
        if (move_cnt == MOVE_LAST) begin
          if (dir_up) begin
            stepped_floor = (floor_o == TOP_FLOOR) ? floor_o : floor_o + FLOOR_W'(1);
          end else begin
            stepped_floor = (floor_o == '0) ? floor_o : floor_o - FLOOR_W'(1);
          end
          floor_next    = stepped_floor;
          dec           = decide(stepped_floor, dir_up, pending, call_req);
          state_next    = dec.st;
          dir_next      = dec.up;
          move_cnt_next = '0;
          door_cnt_next = '0;
        end else begin
          move_cnt_next = move_cnt + MOVE_W'(1);
        end
      end
      DOORS: begin
        if (call_req[floor_o]) begin
          door_cnt_next = '0;
        end else if (door_hold) begin
          door_cnt_next = door_cnt;
        end else if (door_cnt == DOOR_LAST) begin
          dec           = decide(floor_o, dir_up, pending, call_req);
          state_next    = dec.st;
          dir_next      = dec.up;
          move_cnt_next = '0;
          door_cnt_next = '0;
        end else begin
          door_cnt_next = door_cnt + DOOR_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        move_cnt_next = '0;
        door_cnt_next = '0;
      end
    endcase
  end

  // Output and bitmap logic. Calls accumulate into pending, except that the
  // floor the doors are open at (or opening at this edge) is masked out, so
  // a call for it is absorbed by the open doors instead of being latched.
  always_comb begin
    clr_mask = '0;
    if ((state == DOORS) || (state_next == DOORS)) begin
      clr_mask = FLOORS'(1) << floor_next;
    end
    pending_next    = (pending | call_req) & ~clr_mask;
    moving_next     = (state_next == MOVE);
    doors_open_next = (state_next == DOORS);
    arrive_next     = (floor_next != floor_o);
  end

  // The car must never be asked to step off either end of the shaft.
  always_ff @(posedge clk) begin
    if (!rst && (state == MOVE) && (move_cnt == MOVE_LAST)) begin
      assert (dir_up ? (floor_o != TOP_FLOOR) : (floor_o != '0));
    end
  end

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lift_scan_ctrl
//
// Purpose:
//   Self-checking bench for lift_scan_ctrl with FLOORS=8, MOVE_CYCLES=4,
//   DOOR_CYCLES=3. A cycle-by-cycle vector table covers a single trip,
//   hand-written sequences cover the multi-cycle corner cases (hold,
//   dwell restart, SCAN ordering, en-route stop, reset while moving), and
//   a randomized phase compares every output against a reference model
//   built from countdown timers and a plain array of pending calls.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_lift_scan_ctrl;

  localparam int FLOORS      = 8;
  localparam int MOVE_CYCLES = 4;
  localparam int DOOR_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  call_req = '0;
  logic        door_hold = 1'b0;
  logic [2:0]  floor_o;
  logic        dir_up;
  logic        moving;
  logic        doors_open;
  logic        arrive;
  logic [7:0]  pending;

  int checks = 0;
  int errors = 0;

  lift_scan_ctrl #(
    .FLOORS      (FLOORS),
    .MOVE_CYCLES (MOVE_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .call_req   (call_req),
    .door_hold  (door_hold),
    .floor_o    (floor_o),
    .dir_up     (dir_up),
    .moving     (moving),
    .doors_open (doors_open),
    .arrive     (arrive),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [7:0] req;
    logic       hold;
    int         f;
    bit         d;
    bit         m;
    bit         o;
    bit         a;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: floor, direction, a per-floor call array and a
  // mode name with countdown timers of remaining cycles.
  int    m_floor;
  bit    m_up;
  bit    m_pend[FLOORS];
  string m_mode;
  int    m_travel_left;
  int    m_dwell_left;
  bit    m_arrive;

  task automatic check_val(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input int f, input bit d,
                              input bit m, input bit o, input bit a,
                              input logic [7:0] p);
    check_val({name, ".floor"},      32'(floor_o),    32'(f));
    check_val({name, ".dir_up"},     32'(dir_up),     32'(d));
    check_val({name, ".moving"},     32'(moving),     32'(m));
    check_val({name, ".doors_open"}, 32'(doors_open), 32'(o));
    check_val({name, ".arrive"},     32'(arrive),     32'(a));
    check_val({name, ".pending"},    32'(pending),    32'(p));
  endtask

  task automatic apply_stimulus(input logic [7:0] req, input logic hold);
    call_req  = req;
    door_hold = hold;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    call_req = '0;
    door_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add_vec(input logic [7:0] req, input logic hold, input int f,
                         input bit d, input bit m, input bit o, input bit a,
                         input logic [7:0] p);
    vec_t v;
    v.req = req; v.hold = hold; v.f = f; v.d = d;
    v.m = m; v.o = o; v.a = a; v.p = p;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] model_pending();
    logic [7:0] r;
    for (int i = 0; i < FLOORS; i++) r[i] = m_pend[i];
    return r;
  endfunction

  // One clock edge of the reference model, driven by the SCAN rules:
  // serve the floor you are at, else keep heading toward work ahead, else
  // turn round toward work behind, else wait.
  task automatic model_step(input logic [7:0] req, input logic hold, input logic r);
    bit    old_pend[FLOORS];
    string next_mode;
    int    f;
    bit    decide_now;
    bit    above;
    bit    below;
    if (r) begin
      m_floor = 0; m_up = 1'b1; m_mode = "idle"; m_arrive = 1'b0;
      m_travel_left = 0; m_dwell_left = 0;
      for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
      return;
    end
    old_pend   = m_pend;
    next_mode  = m_mode;
    f          = m_floor;
    m_arrive   = 1'b0;
    decide_now = 1'b0;
    if (m_mode == "idle") begin
      decide_now = 1'b1;
    end else if (m_mode == "travel") begin
      m_travel_left--;
      if (m_travel_left == 0) begin
        f = m_up ? f + 1 : f - 1;
        m_arrive = 1'b1;
        decide_now = 1'b1;
      end
    end else begin
      if (req[f]) begin
        m_dwell_left = DOOR_CYCLES;
      end else if (!hold) begin
        m_dwell_left--;
        if (m_dwell_left == 0) decide_now = 1'b1;
      end
    end
    if (decide_now) begin
      above = 1'b0;
      below = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
        if (old_pend[i] && i > f) above = 1'b1;
        if (old_pend[i] && i < f) below = 1'b1;
      end
      if (old_pend[f] || req[f]) begin
        next_mode = "dwell";
        m_dwell_left = DOOR_CYCLES;
      end else if (m_up ? above : below) begin
        next_mode = "travel";
        m_travel_left = MOVE_CYCLES;
      end else if (m_up ? below : above) begin
        m_up = !m_up;
        next_mode = "travel";
        m_travel_left = MOVE_CYCLES;
      end else begin
        next_mode = "idle";
      end
    end
    for (int i = 0; i < FLOORS; i++) m_pend[i] = old_pend[i] | req[i];
    if (m_mode == "dwell" || next_mode == "dwell") m_pend[f] = 1'b0;
    m_floor = f;
    m_mode  = next_mode;
  endtask

  initial begin
    int         n;
    int         opens[$];
    bit         was_open;
    bit         injected;
    logic [7:0] req;
    logic       hold;
    logic       r;
    int         sel;

    // Single trip 0 -> 3: one row per clock edge after the call.
    add_vec(8'h08, 1'b0, 0, 1, 0, 0, 0, 8'h08);
    add_vec(8'h00, 1'b0, 0, 1, 1, 0, 0, 8'h08);
    repeat (3) add_vec(8'h00, 1'b0, 0, 1, 1, 0, 0, 8'h08);
    for (int fl = 1; fl <= 3; fl++) begin
      if (fl < 3) begin
        add_vec(8'h00, 1'b0, fl, 1, 1, 0, 1, 8'h08);
        repeat (3) add_vec(8'h00, 1'b0, fl, 1, 1, 0, 0, 8'h08);
      end else begin
        add_vec(8'h00, 1'b0, 3, 1, 0, 1, 1, 8'h00);
      end
    end
    repeat (2) add_vec(8'h00, 1'b0, 3, 1, 0, 1, 0, 8'h00);
    repeat (2) add_vec(8'h00, 1'b0, 3, 1, 0, 0, 0, 8'h00);

    do_reset();
    check_output("reset", 0, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].req, vecs[i].hold);
      check_output($sformatf("vec%0d", i), vecs[i].f, vecs[i].d, vecs[i].m,
                   vecs[i].o, vecs[i].a, vecs[i].p);
    end

    // Call for the floor the car is idling at: doors open on the sampling
    // edge, the car never moves and the call never shows in pending.
    apply_stimulus(8'h08, 1'b0);
    check_output("here_open", 3, 1, 0, 1, 0, 8'h00);
    n = 1;
    for (int k = 0; k < 20 && doors_open; k++) begin
      apply_stimulus(8'h00, 1'b0);
      check_val("here_moving", 32'(moving), 32'd0);
      check_val("here_pending", 32'(pending), 32'h00);
      if (doors_open) n++;
    end
    check_val("here_door_cycles", 32'(n), 32'd3);

    // Door hold for five cycles stretches the dwell to eight.
    apply_stimulus(8'h08, 1'b0);
    n = doors_open ? 1 : 0;
    repeat (5) begin
      apply_stimulus(8'h00, 1'b1);
      if (doors_open) n++;
    end
    for (int k = 0; k < 20 && doors_open; k++) begin
      apply_stimulus(8'h00, 1'b0);
      if (doors_open) n++;
    end
    check_val("hold_door_cycles", 32'(n), 32'd8);

    // Re-pressing the current floor on the second door cycle restarts it.
    apply_stimulus(8'h08, 1'b0);
    n = doors_open ? 1 : 0;
    apply_stimulus(8'h00, 1'b0);
    if (doors_open) n++;
    apply_stimulus(8'h08, 1'b0);
    if (doors_open) n++;
    check_val("restart_pending", 32'(pending), 32'h00);
    for (int k = 0; k < 20 && doors_open; k++) begin
      apply_stimulus(8'h00, 1'b0);
      if (doors_open) n++;
    end
    check_val("restart_door_cycles", 32'(n), 32'd5);
    check_output("restart_end", 3, 1, 0, 0, 0, 8'h00);

    // SCAN order from floor 3 heading up with calls at 1 and 5.
    opens.delete();
    was_open = 1'b0;
    apply_stimulus(8'h22, 1'b0);
    for (int k = 0; k < 200; k++) begin
      apply_stimulus(8'h00, 1'b0);
      if (doors_open && !was_open) opens.push_back(int'(floor_o));
      was_open = doors_open;
      if (opens.size() == 2 && !doors_open && !moving) break;
    end
    check_val("scan_opens", 32'(opens.size()), 32'd2);
    check_val("scan_first", 32'((opens.size() > 0) ? opens[0] : -1), 32'd5);
    check_val("scan_second", 32'((opens.size() > 1) ? opens[1] : -1), 32'd1);
    check_output("scan_end", 1, 0, 0, 0, 0, 8'h00);

    // From floor 1 toward 6; floor 4 called while passing floor 2.
    opens.delete();
    was_open = 1'b0;
    injected = 1'b0;
    n = 0;
    apply_stimulus(8'h40, 1'b0);
    for (int k = 0; k < 200; k++) begin
      if (floor_o == 3'd2 && !injected) begin
        injected = 1'b1;
        apply_stimulus(8'h10, 1'b0);
      end else begin
        apply_stimulus(8'h00, 1'b0);
      end
      if (doors_open) n++;
      if (doors_open && !was_open) opens.push_back(int'(floor_o));
      was_open = doors_open;
      if (opens.size() == 2 && !doors_open && !moving) break;
    end
    check_val("enroute_opens", 32'(opens.size()), 32'd2);
    check_val("enroute_first", 32'((opens.size() > 0) ? opens[0] : -1), 32'd4);
    check_val("enroute_second", 32'((opens.size() > 1) ? opens[1] : -1), 32'd6);
    check_val("enroute_door_cycles", 32'(n), 32'd6);
    check_output("enroute_end", 6, 1, 0, 0, 0, 8'h00);

    // Reset while moving past floor 4 toward floor 6.
    do_reset();
    apply_stimulus(8'h40, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (floor_o == 3'd4 && moving) break;
      apply_stimulus(8'h00, 1'b0);
    end
    check_val("midreset_floor_before", 32'(floor_o), 32'd4);
    check_val("midreset_pending_before", 32'(pending), 32'h40);
    rst = 1'b1;
    apply_stimulus(8'h00, 1'b0);
    rst = 1'b0;
    check_output("midreset_after", 0, 1, 0, 0, 0, 8'h00);
    apply_stimulus(8'h00, 1'b0);
    check_output("midreset_idle", 0, 1, 0, 0, 0, 8'h00);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    apply_stimulus(8'h00, 1'b0);
    model_step(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      req = 8'($urandom);
      else if (sel < 3)  req = 8'(1 << $urandom_range(0, 7));
      else               req = 8'h00;
      hold = ($urandom_range(0, 5) == 0);
      r    = ($urandom_range(0, 399) == 0);
      rst  = r;
      apply_stimulus(req, hold);
      model_step(req, hold, r);
      check_output($sformatf("rand%0d", c), m_floor, m_up, m_mode == "travel",
                   m_mode == "dwell", m_arrive, model_pending());
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
